// File: rtl/rr_mux4_arbiter.sv
// Round-robin 4:1 arbiter/mux with per-owner burst limit; Req -> Gnt/Ack next cycle -> Out/OutValid one cycle later.
// Ack is withheld while Out holds an undrained word; a stalled owner keeps its grant and beat count.
module rr_mux4_arbiter #(
  parameter int unsigned BURST = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  Req,
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  input  logic [31:0] In3,
  input  logic [31:0] In4,
  input  logic        OutReady,
  output logic [3:0]  Gnt,
  output logic [3:0]  Ack,
  output logic [1:0]  Sel,
  output logic [31:0] Out,
  output logic        OutValid
);

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t      r_state;
  logic [3:0]  r_gnt;
  logic [1:0]  r_sel;
  logic [1:0]  r_ptr;
  logic [3:0]  r_cnt;
  logic [31:0] r_out;
  logic        r_vld;

  logic        w_free;
  logic [3:0]  w_ack;
  logic        w_any_ack;
  logic        w_last_beat;
  logic        w_release;
  logic [1:0]  w_win_idle;
  logic [1:0]  w_win_rel;
  logic [31:0] w_in_sel;

  // First set bit after 'last' in circular order; 'last' itself is checked last,
  // which makes a burst-expired owner the lowest-priority candidate.
  function automatic logic [1:0] f_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign w_free      = !r_vld || OutReady;
  assign w_ack       = r_gnt & Req & {4{w_free}};
  assign w_any_ack   = |w_ack;
  assign w_last_beat = (r_cnt == 4'(BURST - 1));
  assign w_release   = (r_state == ST_OWN) && (!Req[r_sel] || (w_any_ack && w_last_beat));
  assign w_win_idle  = f_pick(Req, r_ptr);
  assign w_win_rel   = f_pick(Req, r_sel);

  always_comb begin
    w_in_sel = In1;
    case (r_sel)
      2'd0: w_in_sel = In1;
      2'd1: w_in_sel = In2;
      2'd2: w_in_sel = In3;
      2'd3: w_in_sel = In4;
      default: w_in_sel = In1;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= 2'd3;
      r_cnt   <= '0;
      r_out   <= '0;
      r_vld   <= 1'b0;
    end else begin
      if (w_any_ack) begin
        r_out <= w_in_sel;
        r_vld <= 1'b1;
      end else if (OutReady) begin
        r_vld <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (|Req) begin
            r_state <= ST_OWN;
            r_gnt   <= 4'b0001 << w_win_idle;
            r_sel   <= w_win_idle;
            r_ptr   <= w_win_idle;
            r_cnt   <= '0;
          end
        end
        ST_OWN: begin
          if (w_release) begin
            r_cnt <= '0;
            if (|Req) begin
              r_gnt <= 4'b0001 << w_win_rel;
              r_sel <= w_win_rel;
              r_ptr <= w_win_rel;
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= '0;
            end
          end else if (w_any_ack) begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  assign Gnt      = r_gnt;
  assign Ack      = w_ack;
  assign Sel      = r_sel;
  assign Out      = r_out;
  assign OutValid = r_vld;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: vector table, directed corner sequences, and a randomized run
// checked against a cycle model of the arbitration rules (two instances, BURST=4 and BURST=1).
module tb_rr_mux4_arbiter;

  localparam logic [31:0] D1 = 32'hA5A5_0001;
  localparam logic [31:0] D2 = 32'hA5A5_0002;
  localparam logic [31:0] D3 = 32'hA5A5_0003;
  localparam logic [31:0] D4 = 32'hA5A5_0004;

  logic        clock = 1'b0;
  logic        resetn;
  logic [3:0]  Req;
  logic [31:0] In1, In2, In3, In4;
  logic        OutReady;

  logic [3:0]  gnt_a, ack_a, gnt_b, ack_b;
  logic [1:0]  sel_a, sel_b;
  logic [31:0] out_a, out_b;
  logic        vld_a, vld_b;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  rr_mux4_arbiter #(.BURST(4)) dut_a (
    .clock(clock), .resetn(resetn), .Req(Req),
    .In1(In1), .In2(In2), .In3(In3), .In4(In4), .OutReady(OutReady),
    .Gnt(gnt_a), .Ack(ack_a), .Sel(sel_a), .Out(out_a), .OutValid(vld_a)
  );

  rr_mux4_arbiter #(.BURST(1)) dut_b (
    .clock(clock), .resetn(resetn), .Req(Req),
    .In1(In1), .In2(In2), .In3(In3), .In4(In4), .OutReady(OutReady),
    .Gnt(gnt_b), .Ack(ack_b), .Sel(sel_b), .Out(out_b), .OutValid(vld_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_own[2];   // -1 = nobody owns the output
  int          m_last[2];
  int          m_sel[2];
  int          m_beats[2];
  logic [31:0] m_out[2];
  logic        m_vld[2];
  int          burst_of[2] = '{4, 1};

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [31:0] in_of(input int i);
    case (i)
      0: return In1;
      1: return In2;
      2: return In3;
      default: return In4;
    endcase
  endfunction

  function automatic logic accepts(input int u);
    if (m_own[u] < 0) return 1'b0;
    return Req[m_own[u]] && (!m_vld[u] || OutReady);
  endfunction

  function automatic logic [42:0] expect_vec(input int u);
    logic [3:0] g;
    logic [3:0] a;
    g = (m_own[u] < 0) ? 4'b0000 : (4'b0001 << m_own[u]);
    a = accepts(u) ? g : 4'b0000;
    return {g, 2'(m_sel[u]), a, m_vld[u], m_out[u]};
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_own[u] = -1; m_last[u] = 3; m_sel[u] = 0; m_beats[u] = 0;
      m_out[u] = '0; m_vld[u] = 1'b0;
    end
  endtask

  task automatic model_step(input int u);
    logic acc;
    int   w;
    int   words;
    acc = accepts(u);
    if (acc) begin
      m_out[u] = in_of(m_own[u]);
      m_vld[u] = 1'b1;
    end else if (OutReady) begin
      m_vld[u] = 1'b0;
    end
    if (m_own[u] < 0) begin
      w = pick(Req, m_last[u]);
      if (w >= 0) begin
        m_own[u] = w; m_sel[u] = w; m_last[u] = w; m_beats[u] = 0;
      end
    end else begin
      words = m_beats[u] + (acc ? 1 : 0);
      if (!Req[m_own[u]] || (acc && words == burst_of[u])) begin
        w = pick(Req, m_own[u]);
        m_own[u] = w;
        m_beats[u] = 0;
        if (w >= 0) begin
          m_sel[u] = w; m_last[u] = w;
        end
      end else begin
        m_beats[u] = words;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic do_reset();
    resetn = 1'b0; Req = '0; OutReady = 1'b1;
    #12;
    @(posedge clock); #1;
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [1:0]  sel;
    logic        vld;
    logic [31:0] out;
  } vec_t;

  vec_t tv[14];

  initial begin
    logic [3:0] exp_ack;
    tv[0]  = '{4'b0001, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 32'h0};
    tv[1]  = '{4'b0001, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 32'h0};
    tv[2]  = '{4'b0001, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, D1};
    tv[3]  = '{4'b0000, 1'b1, 4'b0001, 4'b0000, 2'd0, 1'b1, D1};
    tv[4]  = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, D1};
    tv[5]  = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, D1};
    tv[6]  = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 2'd2, 1'b1, D3};
    tv[7]  = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 2'd2, 1'b1, D3};
    tv[8]  = '{4'b0110, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, D3};
    tv[9]  = '{4'b0110, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, D3};
    tv[10] = '{4'b0110, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, D3};
    tv[11] = '{4'b0110, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, D3};
    tv[12] = '{4'b0000, 1'b1, 4'b0010, 4'b0000, 2'd1, 1'b1, D2};
    tv[13] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, D2};

    In1 = D1; In2 = D2; In3 = D3; In4 = D4;
    do_reset();

    // vector table: reset state, first grant latency, stall, burst expiry, hand-over
    for (int i = 0; i < 14; i++) begin
      Req = tv[i].req; OutReady = tv[i].rdy;
      #1;
      check($sformatf("table[%0d]", i),
            {gnt_a, sel_a, ack_a, vld_a, out_a},
            {tv[i].gnt, tv[i].sel, tv[i].ack, tv[i].vld, tv[i].out});
      next_cycle();
    end

    // two requesters held, BURST=4: four words each, alternating, no idle hand-over
    do_reset();
    Req = 4'b0011;
    for (int c = 0; c < 17; c++) begin
      #1;
      exp_ack = (c == 0) ? 4'b0000 : ((((c - 1) / 4) % 2 == 0) ? 4'b0001 : 4'b0010);
      check($sformatf("burst4_ack[%0d]", c), {gnt_a, ack_a}, {exp_ack, exp_ack});
      next_cycle();
    end

    // all requesting, BURST=1: one word each in strict rotation
    do_reset();
    Req = 4'b1111;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      #1;
      check($sformatf("rot_sel[%0d]", c), {sel_b, ack_b}, {2'((c - 1) % 4), 4'b0001 << ((c - 1) % 4)});
      check($sformatf("rot_onehot[%0d]", c), 64'($onehot(gnt_b)), 64'd1);
    end

    // stall for 5 cycles mid-burst: everything frozen, beat count preserved
    do_reset();
    Req = 4'b0101;
    for (int c = 0; c < 11; c++) begin
      In1 = 32'h1000_0000 + 32'(c);
      OutReady = !(c >= 3 && c <= 7);
      #1;
      if (c >= 3 && c <= 7)
        check($sformatf("stall[%0d]", c), {gnt_a, ack_a, vld_a, out_a}, {4'b0001, 4'b0000, 1'b1, 32'h1000_0002});
      else if (c == 8 || c == 9)
        check($sformatf("resume[%0d]", c), {gnt_a, ack_a}, {4'b0001, 4'b0001});
      else if (c == 10)
        check("after_stall_handover", {gnt_a, ack_a, sel_a}, {4'b0100, 4'b0100, 2'd2});
      next_cycle();
    end
    OutReady = 1'b1;

    // reset mid-burst clears immediately; first grant afterwards goes to lowest index
    do_reset();
    Req = 4'b0011; In1 = D1;
    for (int c = 0; c < 3; c++) next_cycle();
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_a", {gnt_a, ack_a, vld_a, out_a}, 64'd0);
    check("async_reset_b", {gnt_b, ack_b, vld_b, out_b}, 64'd0);
    @(posedge clock); #1;
    Req = 4'b0110;
    resetn = 1'b1;
    #1;
    check("post_reset_idle", {gnt_a, sel_a}, {4'b0000, 2'd0});
    next_cycle();
    check("post_reset_grant", {gnt_a, sel_a, ack_a}, {4'b0010, 2'd1, 4'b0010});

    // randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) Req = 4'($urandom);
      OutReady = ($urandom_range(0, 3) != 0);
      In1 = $urandom; In2 = $urandom; In3 = $urandom; In4 = $urandom;
      #1;
      check($sformatf("rand_a[%0d]", c), {gnt_a, sel_a, ack_a, vld_a, out_a}, expect_vec(0));
      check($sformatf("rand_b[%0d]", c), {gnt_b, sel_b, ack_b, vld_b, out_b}, expect_vec(1));
      model_step(0);
      model_step(1);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
